// File: rtl/range_sensor_scheduler.sv
// Fires N range sensors one at a time, with a guard gap between firings, and captures each echo count.
// Define RSS_WATCHDOG_EN to add a per-measurement watchdog that substitutes TIMEOUT_VAL.
module range_sensor_scheduler #(
   parameter int unsigned N_SENSORS       = 4,
   parameter logic [31:0] GUARD_CYCLES    = 32'd500_000,
   parameter logic [31:0] TIMEOUT_VAL     = 32'd2_320_000,
   parameter logic [31:0] WATCHDOG_CYCLES = 32'd10_000_000
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [N_SENSORS-1:0]         en_mask_i,
   input  logic                         go_i,
   input  logic                         cont_i,
   input  logic                         stop_i,
   input  logic [N_SENSORS-1:0]         sens_done_i,
   input  logic [32*N_SENSORS-1:0]      sens_dist_i,
   input  logic [N_SENSORS-1:0]         ack_i,
   output logic [N_SENSORS-1:0]         start_o,
   output logic [32*N_SENSORS-1:0]      dist_o,
   output logic [N_SENSORS-1:0]         fresh_o,
   output logic [N_SENSORS-1:0]         err_o,
   output logic                         sweep_done_o,
   output logic                         busy_o,
   output logic [$clog2(N_SENSORS)-1:0] cur_idx_o
);
   localparam int IW = $clog2(N_SENSORS);
   localparam int PW = IW + 1;
   localparam logic [N_SENSORS-1:0] ONE = N_SENSORS'(1);

   typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, GUARD, SWEEP_END} state_t;

   state_t               state_q, state_d;
   logic [N_SENSORS-1:0] mask_q;
   logic [PW-1:0]        ptr_q;
   logic [31:0]          cnt_q;
   logic                 stop_q;
   logic                 found;
   logic [IW-1:0]        found_idx;
   logic                 cur_done;
   logic                 wd_expire;
   logic                 stop_any;
   logic                 capture;
   logic [N_SENSORS-1:0] cur_bit;
   logic [IW+4:0]        slice_lo;

   assign cur_bit  = ONE << cur_idx_o;
   assign slice_lo = {cur_idx_o, 5'd0};
   assign cur_done = sens_done_i[cur_idx_o];
   assign stop_any = stop_q | stop_i;
   assign capture  = (state_q == WAIT) && (cur_done || wd_expire);

   // ptr is one bit wider than an index so that stepping past the last sensor reads as "none left"
   always_comb begin
      found     = 1'b0;
      found_idx = '0;
      for (int i = 0; i < int'(N_SENSORS); i++) begin
         if (!found && mask_q[i] && (PW'(i) >= ptr_q)) begin
            found     = 1'b1;
            found_idx = IW'(i);
         end
      end
   end

`ifdef RSS_WATCHDOG_EN
   logic [31:0] wdog_q;

   assign wd_expire = (wdog_q == 32'd0) && !cur_done;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wdog_q <= '0;
         err_o  <= '0;
      end else begin
         if (state_q == START) begin
            wdog_q <= WATCHDOG_CYCLES;
         end else if ((state_q == WAIT) && (wdog_q != 32'd0)) begin
            wdog_q <= wdog_q - 32'd1;
         end
         if ((state_q == WAIT) && cur_done) begin
            err_o <= err_o & ~cur_bit;
         end else if ((state_q == WAIT) && wd_expire) begin
            err_o <= err_o | cur_bit;
         end
      end
   end
`else
   logic unused_wdog_cfg;

   assign unused_wdog_cfg = ^WATCHDOG_CYCLES;
   assign wd_expire       = 1'b0;
   assign err_o           = '0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      start_o      = '0;
      sweep_done_o = 1'b0;
      busy_o       = (state_q != IDLE);
      case (state_q)
         IDLE:      if (go_i) state_d = SELECT;
         SELECT:    state_d = found ? START : SWEEP_END;
         START: begin
            start_o = cur_bit;
            state_d = WAIT;
         end
         WAIT:      if (capture) state_d = GUARD;
         GUARD:     if (cnt_q == 32'd0) state_d = stop_any ? IDLE : SELECT;
         SWEEP_END: begin
            sweep_done_o = 1'b1;
            state_d      = (cont_i && !stop_any) ? SELECT : IDLE;
         end
         default:   state_d = IDLE;
      endcase
   end

   // A capture setting a fresh bit overrides an ack clearing it in the same cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mask_q    <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         stop_q    <= 1'b0;
         cur_idx_o <= '0;
         dist_o    <= '0;
         fresh_o   <= '0;
      end else begin
         fresh_o <= (fresh_o & ~ack_i) | (capture ? cur_bit : '0);
         if ((state_q != IDLE) && stop_i) stop_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (go_i) begin
                  mask_q <= en_mask_i;
                  ptr_q  <= '0;
                  stop_q <= 1'b0;
               end
            end
            SELECT: if (found) cur_idx_o <= found_idx;
            WAIT: begin
               if (capture) begin
                  dist_o[slice_lo +: 32] <= cur_done ? sens_dist_i[slice_lo +: 32] : TIMEOUT_VAL;
                  cnt_q                  <= GUARD_CYCLES;
               end
            end
            GUARD: begin
               if (cnt_q != 32'd0) begin
                  cnt_q <= cnt_q - 32'd1;
               end else begin
                  ptr_q <= {1'b0, cur_idx_o} + PW'(1);
               end
            end
            SWEEP_END: begin
               if (cont_i && !stop_any) begin
                  mask_q <= en_mask_i;
                  ptr_q  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_range_sensor_scheduler.sv
// Self-checking bench for range_sensor_scheduler: directed scenarios plus randomized sweeps
// checked against a schedule/result model derived from the sweep timing rules.
module tb_range_sensor_scheduler;
   localparam int N = 4;
   localparam int GUARD = 4;
   localparam logic [31:0] TIMEOUT = 32'd2_320_000;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic [N-1:0]   en_mask_i;
   logic           go_i;
   logic           cont_i;
   logic           stop_i;
   logic [N-1:0]   sens_done_i;
   logic [32*N-1:0] sens_dist_i;
   logic [N-1:0]   ack_i;
   logic [N-1:0]   start_o;
   logic [32*N-1:0] dist_o;
   logic [N-1:0]   fresh_o;
   logic [N-1:0]   err_o;
   logic           sweep_done_o;
   logic           busy_o;
   logic [1:0]     cur_idx_o;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int base = 0;
   int cap_idx = -1;
   logic [31:0] cap_val;
   logic [31:0] model_dist[N];
   logic [N-1:0] model_fresh;
   logic [N-1:0] model_err;

   range_sensor_scheduler #(
      .N_SENSORS(N),
      .GUARD_CYCLES(32'(GUARD)),
      .TIMEOUT_VAL(TIMEOUT),
      .WATCHDOG_CYCLES(32'd50)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .en_mask_i(en_mask_i),
      .go_i(go_i),
      .cont_i(cont_i),
      .stop_i(stop_i),
      .sens_done_i(sens_done_i),
      .sens_dist_i(sens_dist_i),
      .ack_i(ack_i),
      .start_o(start_o),
      .dist_o(dist_o),
      .fresh_o(fresh_o),
      .err_o(err_o),
      .sweep_done_o(sweep_done_o),
      .busy_o(busy_o),
      .cur_idx_o(cur_idx_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500_000;
      $display("[TB] FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "[TB] simulation did not finish");
   end

   function automatic logic [N-1:0] onehot(input int k);
      return 4'b0001 << k;
   endfunction

   task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_model(input string tag);
      logic [127:0] exp_d;
      for (int i = 0; i < N; i++) exp_d[32*i +: 32] = model_dist[i];
      check_output({tag, "_dist"}, dist_o, exp_d);
      check_output({tag, "_fresh"}, 128'(fresh_o), 128'(model_fresh));
      check_output({tag, "_err"}, 128'(err_o), 128'(model_err));
   endtask

   // One clock: update the model from the inputs sampled at this edge, then release pulses
   task automatic step();
      @(posedge clk_i);
      if (rst_i) begin
         for (int i = 0; i < N; i++) model_dist[i] = '0;
         model_fresh = '0;
         model_err   = '0;
      end else begin
         if (cap_idx >= 0) begin
            model_dist[cap_idx] = cap_val;
            model_err[cap_idx]  = 1'b0;
         end
         model_fresh = (model_fresh & ~ack_i) | ((cap_idx >= 0) ? onehot(cap_idx) : 4'b0000);
      end
      #1;
      cyc++;
      go_i        = 1'b0;
      stop_i      = 1'b0;
      sens_done_i = '0;
      ack_i       = '0;
      cap_idx     = -1;
   endtask

   task automatic run_to(input int t);
      while (cyc < base + t) step();
   endtask

   task automatic capture_done(input int k, input logic [31:0] val);
      sens_done_i[k]         = 1'b1;
      sens_dist_i[32*k +: 32] = val;
      cap_idx                = k;
      cap_val                = val;
   endtask

   // One sweep with random echo delays, stray done pulses, acks and go pulses
   task automatic run_sweep(input logic [N-1:0] mask, input bit do_stop);
      int list[$];
      int s_at[N];
      int d_at[N];
      logic [31:0] dv[N];
      int t, c0, stop_k, n_served, sweep_end, busy_end, wait_k;
      logic [N-1:0] exp_start, junk;
      logic [1:0] exp_idx;
      for (int i = 0; i < N; i++) begin
         s_at[i] = -100;
         d_at[i] = -100;
         dv[i]   = '0;
         if (mask[i]) list.push_back(i);
      end
      c0 = cyc;
      t  = c0 + 2;
      foreach (list[j]) begin
         s_at[list[j]] = t;
         d_at[list[j]] = t + int'($urandom_range(12, 1));
         dv[list[j]]   = $urandom;
         t             = d_at[list[j]] + GUARD + 3;
      end
      stop_k = -1;
      if (do_stop && list.size() > 0) stop_k = int'($urandom_range(list.size() - 1, 0));
      if (stop_k >= 0) begin
         n_served  = stop_k + 1;
         sweep_end = -1;
         busy_end  = d_at[list[stop_k]] + GUARD + 1;
      end else begin
         n_served  = list.size();
         sweep_end = (list.size() == 0) ? c0 + 2 : d_at[list[list.size() - 1]] + GUARD + 3;
         busy_end  = sweep_end;
      end
      cont_i    = 1'b0;
      en_mask_i = mask;
      go_i      = 1'b1;
      step();
      en_mask_i = 4'($urandom);
      while (cyc <= busy_end + 2) begin
         exp_start = '0;
         exp_idx   = '0;
         wait_k    = -1;
         for (int j = 0; j < n_served; j++) begin
            if (cyc == s_at[list[j]]) begin
               exp_start = onehot(list[j]);
               exp_idx   = 2'(list[j]);
            end
            if (cyc > s_at[list[j]] && cyc <= d_at[list[j]]) wait_k = list[j];
         end
         check_output("sweep_start", 128'(start_o), 128'(exp_start));
         if (exp_start != '0) check_output("sweep_cur_idx", 128'(cur_idx_o), 128'(exp_idx));
         check_output("sweep_done", 128'(sweep_done_o), 128'(cyc == sweep_end));
         check_output("sweep_busy", 128'(busy_o), 128'(cyc <= busy_end));
         check_model("sweep");
         junk = 4'($urandom);
         if (wait_k >= 0) junk = junk & ~onehot(wait_k);
         for (int i = 0; i < N; i++) sens_dist_i[32*i +: 32] = $urandom;
         sens_done_i = junk;
         if (wait_k >= 0 && cyc == d_at[wait_k]) capture_done(wait_k, dv[wait_k]);
         ack_i = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'b0000;
         if (cyc <= busy_end && $urandom_range(7, 0) == 0) go_i = 1'b1;
         if (stop_k >= 0 && cyc == s_at[list[stop_k]] + 1) stop_i = 1'b1;
         step();
      end
   endtask

   initial begin
      bit fired;
      rst_i       = 1'b1;
      en_mask_i   = '0;
      go_i        = 1'b0;
      cont_i      = 1'b0;
      stop_i      = 1'b0;
      sens_done_i = '0;
      sens_dist_i = '0;
      ack_i       = '0;
      for (int i = 0; i < N; i++) model_dist[i] = '0;
      model_fresh = '0;
      model_err   = '0;
      step();
      step();
      check_output("rst_start", 128'(start_o), 128'(0));
      check_output("rst_sweep_done", 128'(sweep_done_o), 128'(0));
      check_output("rst_busy", 128'(busy_o), 128'(0));
      check_output("rst_cur_idx", 128'(cur_idx_o), 128'(0));
      check_model("rst");
      rst_i = 1'b0;
      step();

      $display("[TB] basic sweep, stray done, ack collision, continuous mode, stop");
      base      = cyc;
      cont_i    = 1'b1;
      en_mask_i = 4'b0101;
      go_i      = 1'b1;
      step();
      en_mask_i = 4'b1111;
      run_to(2);
      check_output("basic_start0", 128'(start_o), 128'(4'b0001));
      check_output("basic_idx0", 128'(cur_idx_o), 128'(0));
      run_to(3);
      check_output("basic_start_pulse", 128'(start_o), 128'(0));
      run_to(10);
      sens_done_i[3]          = 1'b1;
      sens_dist_i[32*3 +: 32] = 32'd9999;
      step();
      run_to(20);
      capture_done(0, 32'd1234);
      ack_i = 4'b0001;
      step();
      check_model("basic_cap0");
      check_output("basic_dist0", 128'(dist_o[31:0]), 128'(32'd1234));
      check_output("basic_fresh0", 128'(fresh_o), 128'(4'b0001));
      run_to(26);
      check_output("basic_no_early_start", 128'(start_o), 128'(0));
      run_to(27);
      check_output("basic_start2", 128'(start_o), 128'(4'b0100));
      check_output("basic_idx2", 128'(cur_idx_o), 128'(2));
      run_to(30);
      capture_done(2, 32'd777);
      step();
      check_model("basic_cap2");
      run_to(36);
      check_output("basic_no_early_done", 128'(sweep_done_o), 128'(0));
      run_to(37);
      check_output("basic_sweep_done", 128'(sweep_done_o), 128'(1));
      run_to(38);
      check_output("cont_done_pulse", 128'(sweep_done_o), 128'(0));
      check_output("cont_busy", 128'(busy_o), 128'(1));
      run_to(39);
      check_output("cont_restart", 128'(start_o), 128'(4'b0001));
      run_to(41);
      stop_i = 1'b1;
      step();
      run_to(45);
      capture_done(0, 32'd55);
      step();
      check_model("stop_cap");
      cont_i = 1'b0;
      run_to(50);
      check_output("stop_guard_busy", 128'(busy_o), 128'(1));
      run_to(51);
      check_output("stop_idle", 128'(busy_o), 128'(0));
      check_output("stop_no_done", 128'(sweep_done_o), 128'(0));
      run_to(52);
      check_output("stop_no_start", 128'(start_o), 128'(0));
      ack_i = 4'b1111;
      step();
      check_model("ack_all");

      $display("[TB] empty mask");
      base      = cyc;
      en_mask_i = 4'b0000;
      go_i      = 1'b1;
      step();
      check_output("empty_busy", 128'(busy_o), 128'(1));
      run_to(2);
      check_output("empty_sweep_done", 128'(sweep_done_o), 128'(1));
      check_output("empty_no_start", 128'(start_o), 128'(0));
      run_to(3);
      check_output("empty_idle", 128'(busy_o), 128'(0));

      $display("[TB] randomized sweeps");
      for (int n = 0; n < 16; n++) begin
         run_sweep(4'($urandom), ($urandom_range(3, 0) == 0));
      end

`ifdef RSS_WATCHDOG_EN
      $display("[TB] watchdog");
      base      = cyc;
      en_mask_i = 4'b0001;
      go_i      = 1'b1;
      step();
      run_to(2);
      check_output("wdog_start", 128'(start_o), 128'(4'b0001));
      fired = 1'b0;
      for (int i = 0; i < 100 && !fired; i++) begin
         if (err_o[0]) fired = 1'b1;
         else step();
      end
      check_output("wdog_fired", 128'(fired), 128'(1));
      check_output("wdog_latency_ok", 128'((cyc - base - 2 >= 45) && (cyc - base - 2 <= 56)), 128'(1));
      model_dist[0]  = TIMEOUT;
      model_fresh[0] = 1'b1;
      model_err[0]   = 1'b1;
      check_model("wdog");
      for (int i = 0; i < 30 && busy_o; i++) step();
      check_output("wdog_idle", 128'(busy_o), 128'(0));
      run_sweep(4'b0001, 1'b0);
      check_model("wdog_cleared");
`endif

      $display("[TB] reset mid-measurement");
      base      = cyc;
      en_mask_i = 4'b0010;
      go_i      = 1'b1;
      step();
      run_to(4);
      check_output("midrst_busy_before", 128'(busy_o), 128'(1));
      rst_i = 1'b1;
      #1;
      check_output("midrst_busy", 128'(busy_o), 128'(0));
      check_output("midrst_dist", dist_o, 128'(0));
      check_output("midrst_fresh", 128'(fresh_o), 128'(0));
      check_output("midrst_cur_idx", 128'(cur_idx_o), 128'(0));
      step();
      rst_i = 1'b0;
      step();
      check_output("midrst_stays_idle", 128'(busy_o), 128'(0));
      check_model("midrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/range_sensor_scheduler.md
# range_sensor_scheduler

Sequences measurements across N ultrasonic range-sensor controllers, one per sensor, so that only one transducer fires at a time and echoes cannot cross-couple. It sits between the MicroBlaze MCS register interface and the per-sensor range-sensor FSMD instances. It issues one start request at a time and captures each returned echo-duration count into a per-sensor result register. It also inserts a programmable guard interval between firings.

## Interface
- `N_SENSORS`, default 4: number of sensor controllers served, from 2 to 16.
- `GUARD_CYCLES`, default 32'd500_000: idle cycles inserted after each capture, before the next start.
- `TIMEOUT_VAL`, default 32'd2_320_000: distance value written when the watchdog fires.
- `WATCHDOG_CYCLES`, default 32'd10_000_000: maximum number of WAIT cycles. Used only when `RSS_WATCHDOG_EN` is defined.
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `en_mask_i`, input, N: per-sensor enable. Latched at each sweep start.
- `go_i`, input, 1: single-cycle pulse that starts a sweep. Sampled only in IDLE.
- `cont_i`, input, 1: continuous mode. Level, sampled at SWEEP_END.
- `stop_i`, input, 1: pulse that requests an abort after the current measurement. Ignored in IDLE.
- `sens_done_i`, input, N: per-sensor done pulse from the controllers.
- `sens_dist_i`, input, 32·N: flattened distances. Sensor i uses bits [32i+31:32i].
- `ack_i`, input, N: clears the matching `fresh_o` bits.
- `start_o`, output, N: one-hot, single-cycle request to sensor i.
- `dist_o`, output, 32·N: flattened captured distances, same slicing as `sens_dist_i`.
- `fresh_o`, output, N: sticky "new result" flags.
- `err_o`, output, N: per-sensor watchdog error flags.
- `sweep_done_o`, output, 1: single-cycle pulse at the end of each complete sweep.
- `busy_o`, output, 1: high in every state except IDLE.
- `cur_idx_o`, output, $clog2(N): index of the sensor being served.

## Operation
- **States:** IDLE, SELECT, START, WAIT, GUARD, SWEEP_END.
- **IDLE**
  - On `go_i`: latch `en_mask_i`, set ptr=0, clear stop_pending, go to SELECT.
  - `go_i` in any other state is ignored.
- **SELECT**
  - Find the lowest index ≥ ptr with its latched mask bit set.
  - If found: set `cur_idx_o`, go to START. Otherwise go to SWEEP_END.
  - An all-zero mask leads to SWEEP_END with no start issued.
- **START**
  - `start_o[cur_idx]`=1 for this cycle only.
  - Load the watchdog counter, go to WAIT.
- **WAIT**
  - On `sens_done_i[cur_idx]`: `dist_o` slice ← `sens_dist_i` slice, set `fresh_o[cur_idx]`, clear `err_o[cur_idx]`.
  - Then load cnt=`GUARD_CYCLES` and go to GUARD.
  - Done pulses from other sensors are ignored.
- **GUARD**
  - Decrement cnt. At cnt==0:
    - if stop_pending, go to IDLE with no `sweep_done_o`;
    - otherwise set ptr=cur_idx+1 and go to SELECT.
  - A ptr value that wraps past N-1 counts as "not found" in SELECT.
- **SWEEP_END**
  - `sweep_done_o`=1 for this cycle.
  - If `cont_i` is high and stop_pending is low: re-latch `en_mask_i`, set ptr=0, go to SELECT. Otherwise go to IDLE.
- **stop_i**
  - Sets stop_pending in any non-IDLE state.
  - If it arrives in SWEEP_END, the next state is IDLE.
- **fresh_o**
  - A bit set by a capture and cleared by `ack_i` in the same cycle ends up set (set wins).
- **Mask changes**
  - Changes to `en_mask_i` during a sweep take effect at the next sweep.

## Timing
- **Reset:** state IDLE.
  - All outputs are 0: `start_o`, `dist_o`, `fresh_o`, `err_o`, `sweep_done_o`, `busy_o`, `cur_idx_o`.
  - ptr, cnt and stop_pending are also 0.
  - A reset mid-measurement aborts immediately. The sensor controller is not notified.
- **Start latency:** `go_i` sampled at edge 0 → `start_o` asserted in cycle 2.
- **Capture latency:** `sens_done_i` sampled at edge k → `dist_o` and `fresh_o` updated in cycle k+1.
- **Next sensor:** with another sensor enabled, the next `start_o` is at cycle k+GUARD_CYCLES+3.
- **Last sensor:** after the guard, SELECT then SWEEP_END. `sweep_done_o` is at cycle k+GUARD_CYCLES+3.
- **Width:** cnt is 32-bit. Decrement only while nonzero, with no wrap.

## Configuration
- **`RSS_WATCHDOG_EN` defined:** WAIT also decrements a 32-bit watchdog counter loaded with `WATCHDOG_CYCLES`.
  - On reaching 0 without done: `dist_o` slice ← `TIMEOUT_VAL`, set `err_o[cur_idx]` and `fresh_o[cur_idx]`, go to GUARD.
  - If done and expiry fall in the same cycle, done wins.
- **Undefined:** WAIT waits indefinitely. `err_o` is tied to 0 and no watchdog logic is generated.

## Test plan
- **Basic sweep:** N=4, GUARD_CYCLES=4, mask=4'b0101, `go_i` at cycle 0.
  - `start_o`=0001 at cycle 2.
  - Done with dist 1234 at cycle 20 → `dist_o`[0]=1234 and `fresh_o`=0001 at cycle 21.
  - `start_o`=0100 at cycle 27.
- **Sweep end and mode:** last done at cycle k → `sweep_done_o` at k+7.
  - With `cont_i`=1: `start_o`=0001 at k+9.
  - With `cont_i`=0: `busy_o`=0 at k+8.
- **Empty mask:** mask=0 with `go_i` at cycle 0 → `sweep_done_o` at cycle 2, no `start_o`, IDLE at cycle 3.
- **Stop:** `stop_i` during WAIT of sensor 0 (mask 0101).
  - Capture occurs, the guard runs, then IDLE; `start_o`[2] never asserts and `sweep_done_o` never asserts.
- **Wrong-sensor done and ack:** `sens_done_i`[3] pulsed during WAIT on sensor 0 → ignored.
  - `ack_i`=0001 in the same cycle as the sensor-0 capture → `fresh_o`[0]=1.
- **Watchdog (`RSS_WATCHDOG_EN`, WATCHDOG_CYCLES=50):** no done → `dist_o`[0]=2_320_000 and `err_o`[0]=1 about 50 cycles after `start_o`.
  - The next normal capture clears `err_o`[0].
